// File: rtl/tetris_cmd_gen_if.sv
// Shared types and the command/response channel between the game
// sequencer (master) and the scene engine (slave).
package tetris_cmd_gen_pkg;
    typedef enum logic [2:0] {
        eNOP    = 3'd0,
        eNew    = 3'd1,
        eRotate = 3'd2,
        eMove   = 3'd3,
        eCheck  = 3'd4
    } opcode_e;

    typedef enum logic [1:0] {
        eUp    = 2'd0,
        eDown  = 2'd1,
        eLeft  = 2'd2,
        eRight = 2'd3
    } direction_e;

    typedef enum logic [2:0] {
        eNon = 3'd0,
        eI   = 3'd1,
        eO   = 3'd2,
        eT   = 3'd3,
        eS   = 3'd4,
        eZ   = 3'd5,
        eJ   = 3'd6,
        eL   = 3'd7
    } tile_type_e;

    typedef struct packed {
        logic [4:0] x_m;
        logic [5:0] y_m;
    } point_t;
endpackage

interface tetris_cmd_gen_if;
    import tetris_cmd_gen_pkg::*;

    logic       cmd_v;
    logic       cmd_ready;
    opcode_e    cmd_op;
    direction_e cmd_dir;
    tile_type_e cmd_tile;
    point_t     cmd_pos;
    logic       resp_v;
    logic       resp_ok;
    logic [2:0] resp_lines;

    modport master (
        output cmd_v, cmd_op, cmd_dir, cmd_tile, cmd_pos,
        input  cmd_ready, resp_v, resp_ok, resp_lines
    );

    modport slave (
        input  cmd_v, cmd_op, cmd_dir, cmd_tile, cmd_pos,
        output cmd_ready, resp_v, resp_ok, resp_lines
    );
endinterface

// File: rtl/tetris_cmd_gen.sv
// Game sequencer: turns buttons and gravity into one engine command
// at a time, spawns tiles, detects landing, scores cleared lines.
module tetris_cmd_gen
    import tetris_cmd_gen_pkg::*;
#(
    parameter int gravity_period_p = 25000000,
    parameter int spawn_x_p        = 6,
    parameter int score_width_p    = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     start_i,
    input  logic                     btn_left_i,
    input  logic                     btn_right_i,
    input  logic                     btn_rotate_i,
    input  logic                     btn_drop_i,
    tetris_cmd_gen_if.master         cmd_if,
    output logic                     game_over_o,
    output logic [score_width_p-1:0] score_o
);
    localparam int CW = $clog2(gravity_period_p);
    localparam int SW = score_width_p;
    localparam logic [CW-1:0] LP_GMAX = CW'(gravity_period_p - 1);
    localparam logic [CW-1:0] LP_DMAX = CW'((gravity_period_p >> 3) - 1);
    localparam point_t LP_SPAWN = '{x_m: 5'(spawn_x_p), y_m: 6'd0};

    typedef enum logic [3:0] {
        S_IDLE, S_SPAWN, S_WAIT_NEW, S_PLAY, S_ISSUE,
        S_WAIT_MOVE, S_CHECK, S_WAIT_CHECK, S_OVER
    } state_e;

    typedef enum logic [1:0] {
        SEL_ROT, SEL_LEFT, SEL_RIGHT, SEL_DOWN
    } sel_e;

    state_e     r_state;
    sel_e       r_sel;
    logic [7:0] r_lfsr;
    logic       r_left_q;
    logic       r_right_q;
    logic       r_rot_q;
    logic       r_pend_left;
    logic       r_pend_right;
    logic       r_pend_rot;
    logic       r_pend_down;
    logic [CW-1:0] r_cnt;
    logic       r_cmd_v;
    opcode_e    r_cmd_op;
    direction_e r_cmd_dir;
    tile_type_e r_cmd_tile;
    point_t     r_cmd_pos;
    logic       r_game_over;
    logic [SW-1:0] r_score;

    logic       w_xfer;
    logic       w_issue_xfer;
    logic       w_active;
    logic       w_rise_left;
    logic       w_rise_right;
    logic       w_rise_rot;
    logic       w_grav_run;
    logic       w_grav_hit;
    logic       w_spawn_go;
    logic       w_fb;
    logic [CW-1:0] w_limit;
    tile_type_e w_tile;
    logic [3:0] w_points;
    logic [SW:0] w_sum;

    assign w_xfer       = r_cmd_v & cmd_if.cmd_ready;
    assign w_issue_xfer = (r_state == S_ISSUE) & w_xfer;
    assign w_active     = (r_state != S_IDLE) && (r_state != S_OVER);
    assign w_rise_left  = btn_left_i & ~r_left_q & w_active;
    assign w_rise_right = btn_right_i & ~r_right_q & w_active;
    assign w_rise_rot   = btn_rotate_i & ~r_rot_q & w_active;

    assign w_grav_run = (r_state == S_PLAY) ||
                        (r_state == S_ISSUE) ||
                        (r_state == S_WAIT_MOVE);
    assign w_limit    = btn_drop_i ? LP_DMAX : LP_GMAX;
    assign w_grav_hit = w_grav_run && (r_cnt >= w_limit);

    // Every path into SPAWN; gravity restarts for the new tile.
    assign w_spawn_go = ((r_state == S_IDLE) || (r_state == S_OVER)) ?
                        start_i :
                        ((r_state == S_WAIT_CHECK) && cmd_if.resp_v);

    assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_tile = (r_lfsr[2:0] == 3'd0) ? eT :
                    tile_type_e'(r_lfsr[2:0]);

    always_comb begin
        w_points = 4'd8;
        unique case (cmd_if.resp_lines)
            3'd0:    w_points = 4'd0;
            3'd1:    w_points = 4'd1;
            3'd2:    w_points = 4'd3;
            3'd3:    w_points = 4'd5;
            default: w_points = 4'd8;
        endcase
    end

    assign w_sum = {1'b0, r_score} + (SW + 1)'(w_points);

    assign cmd_if.cmd_v    = r_cmd_v;
    assign cmd_if.cmd_op   = r_cmd_op;
    assign cmd_if.cmd_dir  = r_cmd_dir;
    assign cmd_if.cmd_tile = r_cmd_tile;
    assign cmd_if.cmd_pos  = r_cmd_pos;
    assign game_over_o     = r_game_over;
    assign score_o         = r_score;

    // Free-running tile generator.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    // Button edge capture into sticky flags; a new press wins over a clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_left_q     <= 1'b0;
            r_right_q    <= 1'b0;
            r_rot_q      <= 1'b0;
            r_pend_left  <= 1'b0;
            r_pend_right <= 1'b0;
            r_pend_rot   <= 1'b0;
        end else begin
            r_left_q  <= btn_left_i;
            r_right_q <= btn_right_i;
            r_rot_q   <= btn_rotate_i;
            if (w_rise_left) begin
                r_pend_left <= 1'b1;
            end else if (w_issue_xfer && r_sel == SEL_LEFT) begin
                r_pend_left <= 1'b0;
            end
            if (w_rise_right) begin
                r_pend_right <= 1'b1;
            end else if (w_issue_xfer && r_sel == SEL_RIGHT) begin
                r_pend_right <= 1'b0;
            end
            if (w_rise_rot) begin
                r_pend_rot <= 1'b1;
            end else if (w_issue_xfer && r_sel == SEL_ROT) begin
                r_pend_rot <= 1'b0;
            end
        end
    end

    // Gravity timer raising a pending fall step; drop shortens the period.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt       <= '0;
            r_pend_down <= 1'b0;
        end else if (w_spawn_go) begin
            r_cnt       <= '0;
            r_pend_down <= 1'b0;
        end else begin
            if (w_grav_hit) begin
                r_cnt <= '0;
            end else if (w_grav_run) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_grav_hit) begin
                r_pend_down <= 1'b1;
            end else if (w_issue_xfer && r_sel == SEL_DOWN) begin
                r_pend_down <= 1'b0;
            end
        end
    end

    // Game sequencer with registered command payload, score and game-over.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= S_IDLE;
            r_sel       <= SEL_ROT;
            r_cmd_v     <= 1'b0;
            r_cmd_op    <= eNOP;
            r_cmd_dir   <= eUp;
            r_cmd_tile  <= eNon;
            r_cmd_pos   <= '0;
            r_game_over <= 1'b0;
            r_score     <= '0;
        end else begin
            if (w_xfer) begin
                r_cmd_v    <= 1'b0;
                r_cmd_op   <= eNOP;
                r_cmd_dir  <= eUp;
                r_cmd_tile <= eNon;
                r_cmd_pos  <= '0;
            end
            unique case (r_state)
                S_IDLE, S_OVER: begin
                    if (start_i) begin
                        r_score     <= '0;
                        r_game_over <= 1'b0;
                        r_state     <= S_SPAWN;
                        r_cmd_v     <= 1'b1;
                        r_cmd_op    <= eNew;
                        r_cmd_tile  <= w_tile;
                        r_cmd_pos   <= LP_SPAWN;
                    end
                end
                S_SPAWN: begin
                    if (w_xfer) r_state <= S_WAIT_NEW;
                end
                S_WAIT_NEW: begin
                    if (cmd_if.resp_v) begin
                        if (cmd_if.resp_ok) begin
                            r_state <= S_PLAY;
                        end else begin
                            r_state     <= S_OVER;
                            r_game_over <= 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (r_pend_rot) begin
                        r_sel    <= SEL_ROT;
                        r_state  <= S_ISSUE;
                        r_cmd_v  <= 1'b1;
                        r_cmd_op <= eRotate;
                    end else if (r_pend_left) begin
                        r_sel     <= SEL_LEFT;
                        r_state   <= S_ISSUE;
                        r_cmd_v   <= 1'b1;
                        r_cmd_op  <= eMove;
                        r_cmd_dir <= eLeft;
                    end else if (r_pend_right) begin
                        r_sel     <= SEL_RIGHT;
                        r_state   <= S_ISSUE;
                        r_cmd_v   <= 1'b1;
                        r_cmd_op  <= eMove;
                        r_cmd_dir <= eRight;
                    end else if (r_pend_down) begin
                        r_sel     <= SEL_DOWN;
                        r_state   <= S_ISSUE;
                        r_cmd_v   <= 1'b1;
                        r_cmd_op  <= eMove;
                        r_cmd_dir <= eDown;
                    end
                end
                S_ISSUE: begin
                    if (w_xfer) r_state <= S_WAIT_MOVE;
                end
                S_WAIT_MOVE: begin
                    if (cmd_if.resp_v) begin
                        if (r_sel == SEL_DOWN && !cmd_if.resp_ok) begin
                            r_state  <= S_CHECK;
                            r_cmd_v  <= 1'b1;
                            r_cmd_op <= eCheck;
                        end else begin
                            r_state <= S_PLAY;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_xfer) r_state <= S_WAIT_CHECK;
                end
                S_WAIT_CHECK: begin
                    if (cmd_if.resp_v) begin
                        r_score    <= w_sum[SW] ? '1 : w_sum[SW-1:0];
                        r_state    <= S_SPAWN;
                        r_cmd_v    <= 1'b1;
                        r_cmd_op   <= eNew;
                        r_cmd_tile <= w_tile;
                        r_cmd_pos  <= LP_SPAWN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tetris_cmd_gen.sv
// Directed bench for tetris_cmd_gen acting as the scene engine,
// with a game-level model of score, game-over and payload rules.
module tb_tetris_cmd_gen;
    import tetris_cmd_gen_pkg::*;

    localparam int K_MOVE  = 0;
    localparam int K_NEW   = 1;
    localparam int K_CHECK = 2;

    typedef struct {
        logic [2:0] op;
        logic [1:0] dir;
        int         cyc;
    } xrec_t;

    logic clk;
    logic rst_n;
    logic start;
    logic b_left;
    logic b_right;
    logic b_rot;
    logic b_drop;
    logic        go;
    logic [15:0] score;

    tetris_cmd_gen_if bus();

    tetris_cmd_gen #(
        .gravity_period_p(8),
        .spawn_x_p       (6),
        .score_width_p   (16)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .start_i     (start),
        .btn_left_i  (b_left),
        .btn_right_i (b_right),
        .btn_rotate_i(b_rot),
        .btn_drop_i  (b_drop),
        .cmd_if      (bus),
        .game_over_o (go),
        .score_o     (score)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit xf = 0;
    xrec_t xq[$];

    int m_score = 0;
    bit m_over  = 0;
    bit m_idle  = 1;
    int pts[5] = '{0, 1, 3, 5, 8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Transfer log, sampled on the active edge.
    always @(posedge clk) begin
        cyc++;
        xf = 1'b0;
        if (rst_n && bus.cmd_v && bus.cmd_ready) begin
            xf = 1'b1;
            xq.push_back('{bus.cmd_op, bus.cmd_dir, cyc});
        end
    end

    // Per-cycle comparison against the game model and payload rules.
    logic        pv = 1'b0;
    logic [18:0] pp = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            chk("score_model", 32'(score), m_score);
            chk("over_model", 32'(go), 32'(m_over));
            if (m_idle || m_over) chk("quiet_v", 32'(bus.cmd_v), 0);
            if (bus.cmd_v) begin
                if (bus.cmd_op == eMove) begin
                    chk("move_dir", 32'(bus.cmd_dir != eUp), 1);
                end else begin
                    chk("dir_up", 32'(bus.cmd_dir), 32'(eUp));
                end
                if (bus.cmd_op == eNew) begin
                    chk("new_tile", 32'(bus.cmd_tile != eNon), 1);
                    chk("new_pos", 32'(bus.cmd_pos), 32'h180);
                end else begin
                    chk("tile_non", 32'(bus.cmd_tile), 32'(eNon));
                    chk("pos_zero", 32'(bus.cmd_pos), 0);
                end
            end
            if (pv && !xf) begin
                chk("hold_v", 32'(bus.cmd_v), 1);
                chk("hold_pay", 32'({bus.cmd_op, bus.cmd_dir,
                                     bus.cmd_tile, bus.cmd_pos}),
                    32'(pp));
            end
            pv = bus.cmd_v;
            pp = {bus.cmd_op, bus.cmd_dir, bus.cmd_tile, bus.cmd_pos};
        end
    end

    int last_cyc = 0;

    task automatic expect_xfer(input string nm,
                               input logic [2:0] op,
                               input logic [1:0] dir);
        xrec_t e;
        int n = 0;
        while (xq.size() == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (xq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout actual=none expected=%0d", nm, op);
            return;
        end
        e = xq.pop_front();
        chk({nm, "_op"}, 32'(e.op), 32'(op));
        chk({nm, "_dir"}, 32'(e.dir), 32'(dir));
        last_cyc = e.cyc;
    endtask

    task automatic respond(input logic ok,
                           input logic [2:0] lines,
                           input int kind);
        int ln;
        bus.resp_v     = 1'b1;
        bus.resp_ok    = ok;
        bus.resp_lines = lines;
        @(posedge clk);
        if (kind == K_CHECK) begin
            ln = (lines > 3'd4) ? 4 : int'(lines);
            m_score = m_score + pts[ln];
            if (m_score > 65535) m_score = 65535;
        end
        if (kind == K_NEW && !ok) m_over = 1'b1;
        @(negedge clk);
        bus.resp_v     = 1'b0;
        bus.resp_ok    = 1'b0;
        bus.resp_lines = 3'd0;
    endtask

    task automatic start_game();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        m_idle  = 1'b0;
        m_over  = 1'b0;
        m_score = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    int c1;
    int c2;
    logic [18:0] hold;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        b_left = 1'b0;
        b_right = 1'b0;
        b_rot = 1'b0;
        b_drop = 1'b0;
        bus.cmd_ready  = 1'b1;
        bus.resp_v     = 1'b0;
        bus.resp_ok    = 1'b0;
        bus.resp_lines = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_v", 32'(bus.cmd_v), 0);
        chk("rst_op", 32'(bus.cmd_op), 32'(eNOP));
        chk("rst_dir", 32'(bus.cmd_dir), 32'(eUp));
        chk("rst_tile", 32'(bus.cmd_tile), 32'(eNon));
        chk("rst_pos", 32'(bus.cmd_pos), 0);
        chk("rst_go", 32'(go), 0);
        chk("rst_score", 32'(score), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Spawn, then plain gravity every 8 cycles.
        start_game();
        expect_xfer("spawn", eNew, eUp);
        respond(1'b1, 3'd0, K_NEW);
        expect_xfer("grav1", eMove, eDown);
        respond(1'b1, 3'd0, K_MOVE);
        c1 = last_cyc;
        expect_xfer("grav2", eMove, eDown);
        respond(1'b1, 3'd0, K_MOVE);
        chk("grav_gap1", last_cyc - c1, 8);
        c1 = last_cyc;
        expect_xfer("grav3", eMove, eDown);
        chk("grav_gap2", last_cyc - c1, 8);
        chk("score0", 32'(score), 0);
        b_drop = 1'b1;
        respond(1'b1, 3'd0, K_MOVE);

        // Fast fall: one fall step per handshake round trip.
        expect_xfer("drop1", eMove, eDown);
        respond(1'b1, 3'd0, K_MOVE);
        expect_xfer("drop2", eMove, eDown);
        respond(1'b1, 3'd0, K_MOVE);
        c2 = last_cyc;
        expect_xfer("drop3", eMove, eDown);
        chk("drop_gap", last_cyc - c2, 3);
        b_drop = 1'b0;
        respond(1'b1, 3'd0, K_MOVE);
        expect_xfer("drop_tail", eMove, eDown);
        respond(1'b1, 3'd0, K_MOVE);

        // Rotate and left together: rotate first, each once.
        b_rot  = 1'b1;
        b_left = 1'b1;
        repeat (2) @(negedge clk);
        b_rot  = 1'b0;
        b_left = 1'b0;
        expect_xfer("prio_rot", eRotate, eUp);
        respond(1'b1, 3'd0, K_MOVE);
        expect_xfer("prio_left", eMove, eLeft);
        respond(1'b1, 3'd0, K_MOVE);
        expect_xfer("after_left", eMove, eDown);
        respond(1'b1, 3'd0, K_MOVE);

        // Landing and scoring.
        expect_xfer("land1", eMove, eDown);
        respond(1'b0, 3'd0, K_MOVE);
        expect_xfer("check1", eCheck, eUp);
        respond(1'b1, 3'd4, K_CHECK);
        chk("score_4lines", 32'(score), 8);
        expect_xfer("spawn2", eNew, eUp);
        respond(1'b1, 3'd0, K_NEW);
        expect_xfer("land2", eMove, eDown);
        respond(1'b0, 3'd0, K_MOVE);
        expect_xfer("check2", eCheck, eUp);
        respond(1'b1, 3'd2, K_CHECK);
        chk("score_2lines", 32'(score), 11);
        expect_xfer("spawn3", eNew, eUp);
        respond(1'b1, 3'd0, K_NEW);
        expect_xfer("land3", eMove, eDown);
        respond(1'b0, 3'd0, K_MOVE);
        expect_xfer("check3", eCheck, eUp);
        respond(1'b1, 3'd7, K_CHECK);
        chk("score_7lines", 32'(score), 19);

        // Engine stalls the next spawn; a stray response is ignored.
        bus.cmd_ready = 1'b0;
        hold = {bus.cmd_op, bus.cmd_dir, bus.cmd_tile, bus.cmd_pos};
        for (int i = 0; i < 5; i++) begin
            chk("stall_v", 32'(bus.cmd_v), 1);
            chk("stall_op", 32'(bus.cmd_op), 32'(eNew));
            chk("stall_pay", 32'({bus.cmd_op, bus.cmd_dir,
                                  bus.cmd_tile, bus.cmd_pos}),
                32'(hold));
            bus.resp_v  = (i == 1);
            bus.resp_ok = 1'b0;
            @(negedge clk);
        end
        bus.resp_v = 1'b0;
        chk("stall_noxfer", xq.size(), 0);
        bus.cmd_ready = 1'b1;

        // Blocked spawn ends the game; restart clears it.
        expect_xfer("spawn_blk", eNew, eUp);
        respond(1'b0, 3'd0, K_NEW);
        repeat (10) @(negedge clk);
        chk("over_go", 32'(go), 1);
        chk("over_score", 32'(score), 19);
        chk("over_quiet", xq.size(), 0);
        start_game();
        chk("restart_go", 32'(go), 0);
        chk("restart_score", 32'(score), 0);
        expect_xfer("respawn", eNew, eUp);
        respond(1'b1, 3'd0, K_NEW);

        // Reset in the middle of an outstanding fall step.
        expect_xfer("pre_rst", eMove, eDown);
        #2;
        rst_n = 1'b0;
        m_idle  = 1'b1;
        m_over  = 1'b0;
        m_score = 0;
        #1;
        chk("arst_v", 32'(bus.cmd_v), 0);
        chk("arst_op", 32'(bus.cmd_op), 32'(eNOP));
        chk("arst_dir", 32'(bus.cmd_dir), 32'(eUp));
        chk("arst_tile", 32'(bus.cmd_tile), 32'(eNon));
        chk("arst_pos", 32'(bus.cmd_pos), 0);
        chk("arst_go", 32'(go), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        bus.resp_v  = 1'b1;
        bus.resp_ok = 1'b0;
        @(negedge clk);
        bus.resp_v = 1'b0;
        repeat (20) @(negedge clk);
        chk("late_resp_v", 32'(bus.cmd_v), 0);
        chk("late_resp_q", xq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
